// File: rtl/sd_bus_arbiter.sv
// One-owner-at-a-time arbiter for the shared SPI-mode SD bus (CSn/MOSI).
// Sequences init/read/write engines with a deselect gap and a per-grant watchdog.
module sd_bus_arbiter #(
    parameter int GAP_CYC     = 128,
    parameter int TIMEOUT_CYC = 1048576
) (
    input  logic clk,
    input  logic rst,
    input  logic init_req,
    input  logic rd_req,
    input  logic wr_req,
    input  logic init_done,
    input  logic rd_done,
    input  logic wr_done,
    input  logic init_mosi,
    input  logic rd_mosi,
    input  logic wr_mosi,
    input  logic init_csn,
    input  logic rd_csn,
    input  logic wr_csn,
    output logic init_gnt,
    output logic rd_gnt,
    output logic wr_gnt,
    output logic sd_mosi,
    output logic sd_csn,
    output logic init_ok,
    output logic timeout,
    output logic busy
);

    localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_ONE  = GAP_W'(1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_RD   = 3'd2;
    localparam logic [2:0] S_WR   = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;

    logic [2:0]       state;
    logic [WD_W-1:0]  wd_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_wr;
    logic             owner_done;

    // Grants decode the state register directly, so async reset drops them at once.
    assign init_gnt = (state == S_INIT);
    assign rd_gnt   = (state == S_RD);
    assign wr_gnt   = (state == S_WR);
    assign busy     = (state != S_IDLE);

    always_comb begin
        sd_csn     = 1'b1;
        sd_mosi    = 1'b1;
        owner_done = 1'b0;
        case (state)
            S_INIT: begin
                sd_csn     = init_csn;
                sd_mosi    = init_mosi;
                owner_done = init_done;
            end
            S_RD: begin
                sd_csn     = rd_csn;
                sd_mosi    = rd_mosi;
                owner_done = rd_done;
            end
            S_WR: begin
                sd_csn     = wr_csn;
                sd_mosi    = wr_mosi;
                owner_done = wr_done;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_IDLE;
            wd_cnt  <= '0;
            gap_cnt <= '0;
            init_ok <= 1'b0;
            timeout <= 1'b0;
            last_wr <= 1'b1;
        end else begin
            timeout <= 1'b0;
            case (state)
                S_IDLE: begin
                    wd_cnt <= '0;
                    // Re-initialisation invalidates the card until the next init_done.
                    if (init_req) begin
                        state   <= S_INIT;
                        init_ok <= 1'b0;
                    end else if (init_ok && rd_req && (!wr_req || last_wr)) begin
                        state   <= S_RD;
                        last_wr <= 1'b0;
                    end else if (init_ok && wr_req) begin
                        state   <= S_WR;
                        last_wr <= 1'b1;
                    end
                end
                S_INIT, S_RD, S_WR: begin
                    // done takes precedence over a watchdog expiry in the same cycle.
                    if (owner_done) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LOAD;
                        wd_cnt  <= '0;
                        if (state == S_INIT) init_ok <= 1'b1;
                    end else if (wd_cnt == WD_LAST) begin
                        state   <= S_GAP;
                        gap_cnt <= GAP_LOAD;
                        wd_cnt  <= '0;
                        timeout <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_ONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == '0) state <= S_IDLE;
                    else               gap_cnt <= gap_cnt - GAP_ONE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_bus_arbiter.sv
// Directed bench for sd_bus_arbiter: ordering, round-robin, gap timing,
// watchdog, done/expiry collision, async reset and non-owner isolation.
module tb_sd_bus_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic init_req, rd_req, wr_req;
    logic init_done, rd_done, wr_done;
    logic init_mosi, rd_mosi, wr_mosi;
    logic init_csn, rd_csn, wr_csn;
    logic init_gnt, rd_gnt, wr_gnt;
    logic sd_mosi, sd_csn, init_ok, timeout, busy;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sd_bus_arbiter #(.GAP_CYC(128), .TIMEOUT_CYC(1000)) dut (
        .clk(clk), .rst(rst),
        .init_req(init_req), .rd_req(rd_req), .wr_req(wr_req),
        .init_done(init_done), .rd_done(rd_done), .wr_done(wr_done),
        .init_mosi(init_mosi), .rd_mosi(rd_mosi), .wr_mosi(wr_mosi),
        .init_csn(init_csn), .rd_csn(rd_csn), .wr_csn(wr_csn),
        .init_gnt(init_gnt), .rd_gnt(rd_gnt), .wr_gnt(wr_gnt),
        .sd_mosi(sd_mosi), .sd_csn(sd_csn), .init_ok(init_ok),
        .timeout(timeout), .busy(busy)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int k;
        k = 0;
        while (busy && k < 500) begin
            k++;
            tick();
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        #12;
        checks++;
        if ({init_gnt, rd_gnt, wr_gnt, sd_csn, sd_mosi, init_ok, timeout, busy} !== 8'b00011000)
            $display("FAIL reset_outputs: got %b want 00011000",
                     {init_gnt, rd_gnt, wr_gnt, sd_csn, sd_mosi, init_ok, timeout, busy});
        else passes++;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_init_then_rd;
        int n, gapn, bad;
        init_req = 1'b1;
        rd_req   = 1'b1;
        checks++;
        if (init_gnt !== 1'b0) $display("FAIL init_gnt_early: got %b want 0", init_gnt);
        else passes++;
        tick();
        checks++;
        if ({init_gnt, rd_gnt, wr_gnt} !== 3'b100)
            $display("FAIL init_priority: got %b want 100", {init_gnt, rd_gnt, wr_gnt});
        else passes++;
        init_req  = 1'b0;
        init_mosi = 1'b1;
        #1;
        checks++;
        if ({sd_csn, sd_mosi} !== 2'b01)
            $display("FAIL init_mux: got %b want 01", {sd_csn, sd_mosi});
        else passes++;
        init_mosi = 1'b0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        checks++;
        if ({init_gnt, init_ok, busy} !== 3'b011)
            $display("FAIL init_release: got %b want 011", {init_gnt, init_ok, busy});
        else passes++;
        n = 0; gapn = 0; bad = 0;
        while (!rd_gnt && n < 400) begin
            if (sd_csn !== 1'b1 || sd_mosi !== 1'b1) bad++;
            if (busy) gapn++;
            n++;
            tick();
        end
        checks++;
        if (gapn !== 128) $display("FAIL init_gap_len: got %0d want 128", gapn);
        else passes++;
        checks++;
        if (n !== 129 || rd_gnt !== 1'b1)
            $display("FAIL rd_after_init: got %0d cycles gnt=%b want 129 gnt=1", n, rd_gnt);
        else passes++;
        checks++;
        if (bad !== 0) $display("FAIL init_gap_bus_idle: got %0d bad cycles want 0", bad);
        else passes++;
    endtask

    task automatic test_round_robin;
        int n, bad;
        logic exp_rd;
        wr_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            exp_rd = (i % 2 == 0);
            checks++;
            if ({rd_gnt, wr_gnt} !== {exp_rd, ~exp_rd})
                $display("FAIL rr_owner_%0d: got %b want %b", i, {rd_gnt, wr_gnt}, {exp_rd, ~exp_rd});
            else passes++;
            if (exp_rd) rd_mosi = 1'b1; else wr_mosi = 1'b1;
            #1;
            checks++;
            if ({sd_csn, sd_mosi} !== 2'b01)
                $display("FAIL rr_mux_%0d: got %b want 01", i, {sd_csn, sd_mosi});
            else passes++;
            rd_mosi = 1'b0;
            wr_mosi = 1'b0;
            if (exp_rd) rd_done = 1'b1; else wr_done = 1'b1;
            if (i == 3) begin
                rd_req = 1'b0;
                wr_req = 1'b0;
            end
            tick();
            rd_done = 1'b0;
            wr_done = 1'b0;
            if (i < 3) begin
                n = 0; bad = 0;
                while (!(rd_gnt || wr_gnt) && n < 400) begin
                    if (sd_csn !== 1'b1 || sd_mosi !== 1'b1) bad++;
                    n++;
                    tick();
                end
                checks++;
                if (n !== 129 || bad !== 0)
                    $display("FAIL rr_gap_%0d: got %0d cycles %0d bad want 129 0", i, n, bad);
                else passes++;
            end
        end
        wait_idle();
        checks++;
        if ({busy, rd_gnt, wr_gnt} !== 3'b000)
            $display("FAIL rr_final_idle: got %b want 000", {busy, rd_gnt, wr_gnt});
        else passes++;
    endtask

    task automatic test_non_owner_done;
        wr_req = 1'b1;
        tick();
        checks++;
        if (wr_gnt !== 1'b1) $display("FAIL nod_grant: got %b want 1", wr_gnt);
        else passes++;
        wr_req  = 1'b0;
        wr_mosi = 1'b0;
        rd_done = 1'b1;
        rd_mosi = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++;
        if ({wr_gnt, busy, sd_mosi} !== 3'b110)
            $display("FAIL nod_ignored: got %b want 110", {wr_gnt, busy, sd_mosi});
        else passes++;
        rd_mosi = 1'b0;
        tick();
        rd_mosi = 1'b1;
        #1;
        checks++;
        if (sd_mosi !== 1'b0) $display("FAIL nod_mosi_isolated: got %b want 0", sd_mosi);
        else passes++;
        rd_mosi = 1'b0;
        wr_done = 1'b1;
        tick();
        wr_done = 1'b0;
        checks++;
        if ({wr_gnt, busy} !== 2'b01) $display("FAIL nod_release: got %b want 01", {wr_gnt, busy});
        else passes++;
        wait_idle();
    endtask

    task automatic test_timeout;
        int n, bad;
        wr_req = 1'b1;
        tick();
        wr_req = 1'b0;
        n = 0; bad = 0;
        while (wr_gnt && n < 1100) begin
            if (timeout !== 1'b0) bad++;
            n++;
            tick();
        end
        checks++;
        if (n !== 1000 || bad !== 0)
            $display("FAIL wd_grant_len: got %0d cycles %0d early pulses want 1000 0", n, bad);
        else passes++;
        checks++;
        if ({timeout, wr_gnt, busy, init_ok} !== 4'b1011)
            $display("FAIL wd_revoke: got %b want 1011", {timeout, wr_gnt, busy, init_ok});
        else passes++;
        tick();
        checks++;
        if (timeout !== 1'b0) $display("FAIL wd_pulse_width: got %b want 0", timeout);
        else passes++;
        wait_idle();
    endtask

    task automatic test_done_and_expiry;
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        repeat (999) tick();
        checks++;
        if (rd_gnt !== 1'b1) $display("FAIL collide_rd_held: got %b want 1", rd_gnt);
        else passes++;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        checks++;
        if ({timeout, rd_gnt, busy} !== 3'b001)
            $display("FAIL collide_rd: got %b want 001", {timeout, rd_gnt, busy});
        else passes++;
        wait_idle();
        init_req = 1'b1;
        tick();
        init_req = 1'b0;
        checks++;
        if ({init_gnt, init_ok} !== 2'b10)
            $display("FAIL reinit_clears_ok: got %b want 10", {init_gnt, init_ok});
        else passes++;
        repeat (999) tick();
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        checks++;
        if ({timeout, init_gnt, init_ok} !== 3'b001)
            $display("FAIL collide_init: got %b want 001", {timeout, init_gnt, init_ok});
        else passes++;
        wait_idle();
    endtask

    task automatic test_reset_mid_grant;
        int n;
        rd_req = 1'b1;
        tick();
        rd_csn = 1'b0;
        #1;
        checks++;
        if ({rd_gnt, sd_csn} !== 2'b10) $display("FAIL rst_pre: got %b want 10", {rd_gnt, sd_csn});
        else passes++;
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({rd_gnt, sd_csn, init_ok} !== 3'b010)
            $display("FAIL rst_async: got %b want 010", {rd_gnt, sd_csn, init_ok});
        else passes++;
        tick();
        rst = 1'b0;
        repeat (5) tick();
        checks++;
        if ({rd_gnt, busy} !== 2'b00) $display("FAIL rst_rd_blocked: got %b want 00", {rd_gnt, busy});
        else passes++;
        init_req = 1'b1;
        tick();
        init_req  = 1'b0;
        init_done = 1'b1;
        tick();
        init_done = 1'b0;
        n = 0;
        while (!rd_gnt && n < 400) begin
            n++;
            tick();
        end
        checks++;
        if (n !== 129 || rd_gnt !== 1'b1)
            $display("FAIL rst_rd_after_init: got %0d cycles gnt=%b want 129 1", n, rd_gnt);
        else passes++;
        rd_req  = 1'b0;
        rd_done = 1'b1;
        tick();
        rd_done = 1'b0;
        wait_idle();
        checks++;
        if (busy !== 1'b0) $display("FAIL rst_final_idle: got %b want 0", busy);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        {init_req, rd_req, wr_req} = 3'b000;
        {init_done, rd_done, wr_done} = 3'b000;
        {init_mosi, rd_mosi, wr_mosi} = 3'b000;
        {init_csn, rd_csn, wr_csn} = 3'b000;
        test_reset();
        test_init_then_rd();
        test_round_robin();
        test_non_owner_done();
        test_timeout();
        test_done_and_expiry();
        test_reset_mid_grant();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/sd_bus_arbiter.md
# sd_bus_arbiter

Owns the shared SPI-mode SD card bus (CSn, MOSI) and sequences the three command engines that drive it: initialisation, block read and block write. It replaces wired-AND merging with an explicit one-owner-at-a-time grant. It enforces init-before-data ordering and inserts a deselect gap (CSn high, MOSI high) between owners. A per-grant watchdog reclaims the bus from a hung engine. It sits between the engine instances and the top-level SD_CSn/SD_MOSI pins; SD_CK generation stays outside.

## Interface
- GAP_CYC, 128: clk cycles of forced deselect after each ownership ends; 128 = 8 SD clocks at clk/16.
- TIMEOUT_CYC, 1048576: maximum clk cycles a grant may last before forced release.
- clk  in  1  system clock; the single clock of the block.
- rst  in  1  asynchronous, active-high reset.
- init_req, rd_req, wr_req  in  1 each  engine requests the bus; level, held until its gnt is seen.
- init_done, rd_done, wr_done  in  1 each  one-cycle pulse from the owner when its transaction is finished.
- init_mosi, rd_mosi, wr_mosi  in  1 each  engine MOSI.
- init_csn, rd_csn, wr_csn  in  1 each  engine CSn.
- init_gnt, rd_gnt, wr_gnt  out  1 each  registered grant; at most one high at any time.
- sd_mosi  out  1  bus MOSI.
- sd_csn  out  1  bus CSn.
- init_ok  out  1  card initialised; set by init_done.
- timeout  out  1  one-cycle pulse when a grant is revoked by the watchdog.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, INIT, RD, WR, GAP.
- IDLE:
  - init_req has top priority at all times.
  - While init_ok=0, rd_req and wr_req are ignored.
  - When init_ok=1 and both rd_req and wr_req are high, round-robin applies: the engine not served last wins. The last-served bit resets to "write", so the first tie goes to read.
  - A single requester wins immediately.
- INIT/RD/WR:
  - The matching gnt is high.
  - sd_mosi and sd_csn equal that engine's mosi/csn, combinationally muxed by the registered state.
  - In IDLE and GAP: sd_csn=1, sd_mosi=1.
- Leaving a grant:
  - The owner's done pulse moves the state to GAP. done from a non-owner is ignored.
  - INIT+init_done sets init_ok.
  - Granting INIT clears init_ok (re-initialisation), so data engines are blocked until the next init_done.
- Watchdog:
  - A counter with clog2(TIMEOUT_CYC+1) bits clears on grant and increments each granted cycle.
  - When the count reaches TIMEOUT_CYC-1 without done, the arbiter pulses timeout, drops gnt and goes to GAP.
  - If the revoked owner was INIT, init_ok stays 0.
- GAP:
  - The counter loads GAP_CYC-1 and decrements to 0, then the state goes to IDLE.
  - Requests arriving during GAP wait; they are not lost because req is a level.
- Simultaneous done and watchdog expiry in the same cycle: done wins. init_ok is set if the owner is INIT, and no timeout pulse occurs.
- A req that drops before grant is simply not served. A req dropped by the owner mid-grant is ignored; only done or timeout ends the grant.

## Timing
- Reset values: all gnt=0, sd_csn=1, sd_mosi=1, init_ok=0, timeout=0, busy=0, state=IDLE, both counters 0.
- Reset asserted mid-grant: gnt drops and CSn deasserts asynchronously, in the same cycle as reset.
- Grant latency:
  - A req sampled high in IDLE at edge n produces gnt=1 after edge n+1.
  - The bus mux follows in that same cycle.
- Release:
  - done sampled at edge m: gnt=0 and sd_csn=1 after edge m+1.
  - GAP lasts exactly GAP_CYC cycles.
  - The earliest next gnt is at edge m+1+GAP_CYC+1.
- Timeout pulse coincides with the first GAP cycle.
- A grant is never held for more than TIMEOUT_CYC cycles.
- Invariant: never more than one gnt high; no gnt in any GAP cycle.

## Test plan
- Reset, then init_req=1 and rd_req=1 together → only init_gnt rises, 1 cycle after req; rd_gnt stays 0. init_done pulse → sd_csn=1 for exactly 128 cycles, then rd_gnt=1 and init_ok=1.
- init_ok=1 with rd_req and wr_req held high → grants alternate RD, WR, RD, WR across four transactions, each separated by a 128-cycle gap with sd_csn=1 and sd_mosi=1.
- TIMEOUT_CYC=1000, wr owner never pulses done → wr_gnt drops after 1000 granted cycles, timeout pulses for 1 cycle, GAP is entered, and init_ok is unchanged.
- Owner done and watchdog expiry in the same cycle → no timeout pulse, normal GAP; repeated with INIT as owner → init_ok=1.
- rst asserted mid-RD grant while rd_csn=0 → sd_csn=1 and rd_gnt=0 in the same cycle. After release, rd_req is ignored until init completes again.
- rd_done pulsed while WR owns the bus → ignored, WR keeps its grant; rd_mosi toggling has no effect on sd_mosi.
